score_accumulator: RTL

Game score engine that sits directly upstream of the 8-digit seven-segment display controller and drives its 32-bit binary score input. It runs the play/game-over state machine and turns single-cycle hit/miss event pulses into a saturating score with a combo multiplier. It also tracks remaining lives and keeps an optional high-score register.

---
 rtl/score_accumulator.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/score_accumulator.sv
// ---------------------------------------------------------------------------------------------
// score_accumulator
//
// Game score engine feeding the 8-digit seven-segment display controller. It runs the
// IDLE / PLAY / OVER game state machine and turns one-cycle HIT / MISS pulses into a
// saturating score with a combo multiplier. It also tracks remaining lives and, optionally,
// a high-score register.
//
// Optional feature macro: SCORE_HIGH_SCORE_EN
//   defined   : HIGH_SCORE register and NEW_HIGH flag are built.
//   undefined : HIGH_SCORE is tied to 0 and NEW_HIGH is tied to 0.
//
// Parameters:
//   BASE_POINTS   points for a hit at combo 0
//   MAX_SCORE     saturation ceiling for the score
//   COMBO_TIMEOUT idle PLAY cycles before the combo clears (>= 2)
//   LIVES         misses allowed per game (1..3)
//
// Ports:
//   CLK          in   system clock
//   RST          in   asynchronous active-high reset
//   START        in   start-game pulse (accepted in IDLE and OVER)
//   HIT          in   hit event pulse
//   MISS         in   miss event pulse
//   END_GAME     in   forced game-over pulse
//   BINARY_SCORE out  current score (registered)
//   HIGH_SCORE   out  best score since reset (registered)
//   COMBO        out  current combo level 0..7
//   LIVES_LEFT   out  remaining lives
//   STATE        out  00 IDLE, 01 PLAY, 10 OVER
//   NEW_HIGH     out  last finished game beat the previous high score
// ---------------------------------------------------------------------------------------------
module score_accumulator #(
  parameter int unsigned BASE_POINTS   = 10,
  parameter int unsigned MAX_SCORE     = 99_999_999,
  parameter int unsigned COMBO_TIMEOUT = 50_000_000,
  parameter int unsigned LIVES         = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        HIT,
  input  logic        MISS,
  input  logic        END_GAME,
  output logic [31:0] BINARY_SCORE,
  output logic [31:0] HIGH_SCORE,
  output logic [2:0]  COMBO,
  output logic [1:0]  LIVES_LEFT,
  output logic [1:0]  STATE,
  output logic        NEW_HIGH
);

  // -------------------------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------------------------
  // The counter only has to reach COMBO_TIMEOUT-2: the edge that would take it to
  // COMBO_TIMEOUT-1 is the clearing edge itself.
  localparam int unsigned TmoW = (COMBO_TIMEOUT > 2) ? $clog2(COMBO_TIMEOUT) : 1;

  localparam logic [TmoW-1:0] TmoLast   = TmoW'(COMBO_TIMEOUT - 2);
  localparam logic [TmoW-1:0] TmoOne    = TmoW'(1);
  localparam logic [1:0]      LivesInit = 2'(LIVES);
  localparam logic [31:0]     MaxScore  = 32'(MAX_SCORE);
  localparam logic [31:0]     BasePts   = 32'(BASE_POINTS);
  localparam logic [2:0]      ComboMax  = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StOver = 2'b10
  } state_e;

  // -------------------------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------------------------
  state_e state_q, state_d;

  logic [31:0]     score_q, score_d;
  logic [2:0]      combo_q, combo_d;
  logic [1:0]      lives_q, lives_d;
  logic [TmoW-1:0] tmo_q,   tmo_d;

  // -------------------------------------------------------------------------------------------
  // Event decode: one PLAY event per cycle, END_GAME > MISS > HIT > idle.
  // -------------------------------------------------------------------------------------------
  logic in_play;
  logic play_enter;
  logic ev_end;
  logic ev_miss;
  logic ev_hit;
  logic ev_idle;

  always_comb begin
    in_play    = (state_q == StPlay);
    play_enter = START && ((state_q == StIdle) || (state_q == StOver));
    ev_end     = in_play && END_GAME;
    ev_miss    = in_play && !END_GAME && MISS;
    ev_hit     = in_play && !END_GAME && !MISS && HIT;
    ev_idle    = in_play && !END_GAME && !MISS && !HIT;
  end

  // -------------------------------------------------------------------------------------------
  // Hit arithmetic: add BASE_POINTS * (combo + 1) using the pre-increment combo, then
  // clamp at MAX_SCORE. The extra sum bit keeps the clamp correct even if the add wrapped.
  // -------------------------------------------------------------------------------------------
  logic [31:0] combo_plus1;
  logic [31:0] hit_add;
  logic [32:0] hit_sum;
  logic [31:0] hit_score;
  logic [2:0]  combo_next;

  always_comb begin
    combo_plus1 = 32'(combo_q) + 32'd1;
    hit_add     = BasePts * combo_plus1;
    hit_sum     = {1'b0, score_q} + {1'b0, hit_add};
    hit_score   = (hit_sum > {1'b0, MaxScore}) ? MaxScore : hit_sum[31:0];
    combo_next  = (combo_q == ComboMax) ? ComboMax : combo_q + 3'd1;
  end

  // -------------------------------------------------------------------------------------------
  // FSM process 1: state register
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // -------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (START) state_d = StPlay;
      end
      StPlay: begin
        if (END_GAME) begin
          state_d = StOver;
        end else if (MISS && (lives_q == 2'd1)) begin
          state_d = StOver;
        end
      end
      StOver: begin
        if (START) state_d = StPlay;
      end
      default: state_d = StIdle;
    endcase
  end

  // -------------------------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------------------------
  always_comb begin
    score_d = score_q;
    combo_d = combo_q;
    lives_d = lives_q;
    tmo_d   = tmo_q;

    if (play_enter) begin
      score_d = '0;
      combo_d = '0;
      lives_d = LivesInit;
      tmo_d   = '0;
    end else if (ev_end) begin
      // Everything freezes; HIT/MISS in the same cycle are dropped.
    end else if (ev_miss) begin
      combo_d = '0;
      lives_d = lives_q - 2'd1;
      tmo_d   = '0;
    end else if (ev_hit) begin
      score_d = hit_score;
      combo_d = combo_next;
      tmo_d   = '0;
    end else if (ev_idle) begin
      if (tmo_q == TmoLast) begin
        combo_d = '0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TmoOne;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      score_q <= '0;
      combo_q <= '0;
      lives_q <= '0;
      tmo_q   <= '0;
    end else begin
      score_q <= score_d;
      combo_q <= combo_d;
      lives_q <= lives_d;
      tmo_q   <= tmo_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // High-score tracking
  // -------------------------------------------------------------------------------------------
`ifdef SCORE_HIGH_SCORE_EN
  logic [31:0] high_q, high_d;
  logic        new_high_q, new_high_d;
  logic        over_enter;

  always_comb begin
    over_enter = in_play && (state_d == StOver);
    high_d     = high_q;
    new_high_d = new_high_q;
    if (play_enter) begin
      new_high_d = 1'b0;
    end
    // Uses the already-registered score: no hit is credited on the game-over edge.
    if (over_enter && (score_q > high_q)) begin
      high_d     = score_q;
      new_high_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      high_q     <= high_d;
      new_high_q <= new_high_d;
    end
  end
`endif

  // -------------------------------------------------------------------------------------------
  // FSM process 3: outputs (all straight from flops)
  // -------------------------------------------------------------------------------------------
  always_comb begin
    STATE        = state_q;
    BINARY_SCORE = score_q;
    COMBO        = combo_q;
    LIVES_LEFT   = lives_q;
`ifdef SCORE_HIGH_SCORE_EN
    HIGH_SCORE   = high_q;
    NEW_HIGH     = new_high_q;
`else
    HIGH_SCORE   = '0;
    NEW_HIGH     = 1'b0;
`endif
  end

endmodule
